// File: rtl/abl_if.sv
// Bundles the microcode-controlled inputs and the address/carry results of
// the ABL stage. ABL_PAGE_CROSS_EN adds the clr_pcross / pcross pair.
// master: microcode sequencer side, slave: ABL stage.
interface abl_if;
    logic [7:0] DB;
    logic [7:0] REG;
    logic [3:0] op;
    logic       hold_c;
    logic       ld_pc;
    logic       inc_pc;
    logic [7:0] ADL;
    logic [7:0] ABL;
    logic       CO;
    logic       CO_Q;
    logic [7:0] PCL;
`ifdef ABL_PAGE_CROSS_EN
    logic       clr_pcross;
    logic       pcross;

    modport master (
        output DB, REG, op, hold_c, ld_pc, inc_pc, clr_pcross,
        input  ADL, ABL, CO, CO_Q, PCL, pcross
    );
    modport slave (
        input  DB, REG, op, hold_c, ld_pc, inc_pc, clr_pcross,
        output ADL, ABL, CO, CO_Q, PCL, pcross
    );
`else
    modport master (
        output DB, REG, op, hold_c, ld_pc, inc_pc,
        input  ADL, ABL, CO, CO_Q, PCL
    );
    modport slave (
        input  DB, REG, op, hold_c, ld_pc, inc_pc,
        output ADL, ABL, CO, CO_Q, PCL
    );
`endif
endinterface

// File: rtl/abl.sv
// Address Bus Low stage of the 65C02 datapath.
// Computes the next low address byte ADL = base + addend + cin, registers it
// as ABL every cycle and keeps PCL. CO feeds the ABH stage in the same cycle;
// CO_Q keeps it for deferred page-crossing fix-up cycles.
// Optional feature macro: ABL_PAGE_CROSS_EN (adds registered pcross flag and
// its clr_pcross input).
module abl #(
    parameter logic [7:0] RESET_ABL = 8'hFC
) (
    input  logic  clk,
    input  logic  RST,
    abl_if.slave  bus
);

    logic [7:0] base;
    logic [7:0] addend;
    logic       cin;
    logic [8:0] sum;

    logic [7:0] abl_q;
    logic [7:0] pcl_q;
    logic       co_q;

    // Base operand select from op[3:2]
    always_comb begin
        base = 8'h00;
        unique case (bus.op[3:2])
            2'b00: base = abl_q;
            2'b01: base = pcl_q;
            2'b10: base = bus.DB;
            2'b11: base = 8'h00;
        endcase
    end

    // Addend and carry-in select from op[1:0]; decrement adds FF so that
    // CO=1 means "no borrow", matching ABH's ABH+FF+CI
    always_comb begin
        addend = 8'h00;
        cin    = 1'b0;
        unique case (bus.op[1:0])
            2'b00: begin addend = 8'h00;  cin = 1'b0; end
            2'b01: begin addend = bus.REG; cin = 1'b0; end
            2'b10: begin addend = 8'hFF;  cin = 1'b0; end
            2'b11: begin addend = 8'h00;  cin = 1'b1; end
        endcase
    end

    // Nine-bit add; bit 8 is the carry handed to ABH
    always_comb begin
        sum = {1'b0, base} + {1'b0, addend} + {8'h00, cin};
    end

    // Address, carry and PCL registers; PCL loads from the registered ABL
    always_ff @(posedge clk) begin
        if (RST) begin
            abl_q <= RESET_ABL;
            pcl_q <= 8'h00;
            co_q  <= 1'b0;
        end else begin
            abl_q <= sum[7:0];
            if (!bus.hold_c)
                co_q <= sum[8];
            if (bus.ld_pc)
                pcl_q <= abl_q + {7'h00, bus.inc_pc};
        end
    end

`ifdef ABL_PAGE_CROSS_EN
    logic pcross_q;

    // Page-cross flag: set by an indexed add that carries, set beats clear
    always_ff @(posedge clk) begin
        if (RST)
            pcross_q <= 1'b0;
        else if (bus.op[1:0] == 2'b01 && sum[8])
            pcross_q <= 1'b1;
        else if (bus.clr_pcross)
            pcross_q <= 1'b0;
    end

    assign bus.pcross = pcross_q;
`endif

    assign bus.ADL  = sum[7:0];
    assign bus.CO   = sum[8];
    assign bus.ABL  = abl_q;
    assign bus.PCL  = pcl_q;
    assign bus.CO_Q = co_q;

endmodule

// File: doc/abl.md
Name: abl

Overview:
- Address Bus Low stage of the 65C02 datapath. Each cycle it computes the next low address byte ADL, registers it as ABL, and holds PCL (program counter low).
- Drives the carry CO that the Address Bus High stage consumes combinationally, in the same cycle, as its CI input.
- Also keeps a registered copy of the carry for deferred page-crossing fix-up cycles.
- Sits directly upstream of the ABH stage, and is controlled by the same microcode word.

Parameters:
- RESET_ABL, 8'hFC, value loaded into ABL on reset (low byte of the reset vector).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- DB  input  8  data bus
- REG  input  8  index register value (X/Y) from the register file
- op  input  4  ABL operation select (see Behaviour)
- hold_c  input  1  when 1, CO_Q keeps its value
- ld_pc  input  1  load PCL
- inc_pc  input  1  increment applied on PCL load
- ADL  output  8  unregistered next ABL value
- ABL  output  8  registered address bus low
- CO  output  1  carry out of the current ADL add (feeds ABH CI)
- CO_Q  output  1  registered carry
- PCL  output  8  program counter low

Behaviour:
- Reset:
  - When RST=1 at a rising edge: ABL<=RESET_ABL, PCL<=8'h00, CO_Q<=0.
  - RST overrides ld_pc, hold_c and op.
  - Combinational outputs ADL and CO follow op normally during reset.
- op[3:2] selects the base B:
  - 00: ABL
  - 01: PCL
  - 10: DB
  - 11: 8'h00
- op[1:0] selects addend A and carry-in cin:
  - 00: A=00, cin=0
  - 01: A=REG, cin=0
  - 10: A=FF, cin=0 (decrement)
  - 11: A=00, cin=1 (increment)
- Sum is the 9-bit value {CO,ADL} = B + A + cin. It is purely combinational and has zero latency.
- Decrement convention:
  - CO=1 means "no borrow". Example: ABL=05 with op=0010 gives ADL=04, CO=1. ABL=00 with op=0010 gives ADL=FF, CO=0.
  - This matches ABH computing ABH+FF+CI.
- ABL is written every cycle: ABL<=ADL. There is no enable; holding ABL is op=0000.
- CO_Q:
  - If hold_c=0: CO_Q<=CO.
  - If hold_c=1: CO_Q holds.
- PCL:
  - If ld_pc=1: PCL<=(ABL + inc_pc) mod 256. The registered ABL is used, not ADL. Any carry out of this add is discarded.
  - If ld_pc=0: PCL holds.
- Simultaneous events:
  - ld_pc and op=01xx in the same cycle: ADL uses the old PCL and PCL takes the new value. This is ordinary register semantics.
  - Wrap-around: 8-bit results wrap modulo 256. Only CO reports overflow.

Optional Feature:
- Macro: ABL_PAGE_CROSS_EN.
- When defined, the block adds:
  - Output pcross (1 bit, registered, reset 0).
  - Input clr_pcross (1 bit).
- pcross update rules, applied each edge unless RST=1:
  - Set when op[1:0]==01 and CO=1 (indexed add crossed a page).
  - Otherwise cleared when clr_pcross=1.
  - Set has priority over clear when both occur in the same cycle.
- The microcode sequencer uses pcross to insert the page-cross penalty cycle.
- When the macro is not defined, neither port exists and no extra logic is generated.

Test Plan:
- Reset: RST=1 for 1 cycle with ld_pc=1 and op=1001 -> ABL=FC, PCL=00, CO_Q=0 after the edge.
- Indexed add: op=1001, DB=F0, REG=20 -> ADL=10, CO=1 in the same cycle. Next edge: ABL=10, CO_Q=1. With ABL_PAGE_CROSS_EN: pcross=1; then clr_pcross=1 with op=0000 -> pcross=0.
- Increment wrap: ABL=FF, op=0011 -> ADL=00, CO=1. Next edge: ABL=00. Then op=0011 -> ADL=01, CO=0.
- Decrement/borrow: ABL=05, op=0010 -> ADL=04, CO=1. Next: ABL=00, op=0010 -> ADL=FF, CO=0.
- PC load: ABL=FF, ld_pc=1, inc_pc=1 -> PCL=00 (carry discarded). ABL=34, ld_pc=1, inc_pc=0 -> PCL=34. With ld_pc=0, PCL is stable over 10 random ops.
- Carry hold: CO_Q=1, hold_c=1, op=0000 on ABL=10 (CO=0) -> CO_Q stays 1. Next cycle hold_c=0 -> CO_Q=0.
